inorder_split: RTL and testbench

- Packet-granular 1-to-2 splitter on the snooper side of the packet memory write interface.
- Upstream is the snooper (or a previous split stage); downstream are two packetmem/VM write ports (left, right).
- With STRICT_ORDER=1, packets are dealt in strict alternation: left, right, left, ... This lets the forward-side combiner recover arrival order by alternating the same way.
- The selection is locked for the duration of a packet. Writes arriving with no eligible target are dropped and counted.

---
 rtl/inorder_split_pkg.sv | 23 ++
 rtl/inorder_split_sel_fsm.sv | 64 ++++++
 rtl/inorder_split.sv | 84 ++++++++
 tb/tb_inorder_split.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inorder_split_pkg.sv
// Shared encodings for the in-order splitter and its forward-side combiner.
// Both sides must agree on the side encoding so alternation lines up.
package inorder_split_pkg;

    localparam int unsigned DefaultAddrWidth = 9;
    localparam int unsigned PlenWidth        = DefaultAddrWidth + 1;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } split_state_e;

    typedef enum logic {
        SideLeft  = 1'b0,
        SideRight = 1'b1
    } split_side_e;

    // Packet length needs one extra bit to hold a full-memory packet.
    function automatic int unsigned plen_width(int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/inorder_split_sel_fsm.sv
// Side selection for the splitter: packet lock, strict-alternation turn and
// the idle-time candidate choice.
module inorder_split_sel_fsm
    import inorder_split_pkg::*;
#(
    parameter bit STRICT_ORDER = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic        done_i,
    input  logic        ready_left_i,
    input  logic        ready_right_i,
    output split_side_e active_o,
    output logic        ready_o
);

    split_state_e state_q, state_d;
    split_side_e  sel_q, sel_d;
    split_side_e  turn_q, turn_d;
    split_side_e  cand;

    always_comb begin
        cand = SideRight;
        if (STRICT_ORDER) begin
            cand = turn_q;
        end else if (ready_left_i) begin
            cand = SideLeft;
        end
        active_o = (state_q == StBusy) ? sel_q : cand;
        // Gate with reset so nothing is accepted while the packetmem resets too.
        ready_o  = ~rst_i & ((active_o == SideRight) ? ready_right_i : ready_left_i);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        turn_d  = turn_q;
        if (ready_o) begin
            if (done_i) begin
                state_d = StIdle;
                if (STRICT_ORDER) begin
                    turn_d = split_side_e'(~active_o);
                end
            end else if (wr_en_i && state_q == StIdle) begin
                state_d = StBusy;
                sel_d   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= SideLeft;
            turn_q  <= SideLeft;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            turn_q  <= turn_d;
        end
    end

endmodule

// File: rtl/inorder_split.sv
// Packet-granular 1-to-2 splitter on the packetmem write interface: routes
// whole packets to left/right and keeps saturating packet/drop statistics.
module inorder_split
    import inorder_split_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter bit          STRICT_ORDER = 1'b1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] snooper_wr_addr_i,
    input  logic [DATA_WIDTH-1:0] snooper_wr_data_i,
    input  logic                  snooper_wr_en_i,
    input  logic                  snooper_done_i,
    output logic                  ready_for_snooper_o,
    output logic [ADDR_WIDTH-1:0] snooper_wr_addr_left_o,
    output logic [ADDR_WIDTH-1:0] snooper_wr_addr_right_o,
    output logic [DATA_WIDTH-1:0] snooper_wr_data_left_o,
    output logic [DATA_WIDTH-1:0] snooper_wr_data_right_o,
    output logic                  snooper_wr_en_left_o,
    output logic                  snooper_wr_en_right_o,
    output logic                  snooper_done_left_o,
    output logic                  snooper_done_right_o,
    input  logic                  ready_for_snooper_left_i,
    input  logic                  ready_for_snooper_right_i,
    output logic [CNT_WIDTH-1:0]  pkt_count_o,
    output logic [CNT_WIDTH-1:0]  drop_count_o
);

    split_side_e          active;
    logic                 ready;
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d, drop_q, drop_d;

    inorder_split_sel_fsm #(
        .STRICT_ORDER(STRICT_ORDER)
    ) u_sel_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_en_i      (snooper_wr_en_i),
        .done_i       (snooper_done_i),
        .ready_left_i (ready_for_snooper_left_i),
        .ready_right_i(ready_for_snooper_right_i),
        .active_o     (active),
        .ready_o      (ready)
    );

    assign ready_for_snooper_o     = ready;
    assign snooper_wr_addr_left_o  = snooper_wr_addr_i;
    assign snooper_wr_addr_right_o = snooper_wr_addr_i;
    assign snooper_wr_data_left_o  = snooper_wr_data_i;
    assign snooper_wr_data_right_o = snooper_wr_data_i;
    assign snooper_wr_en_left_o    = snooper_wr_en_i & ready & (active == SideLeft);
    assign snooper_wr_en_right_o   = snooper_wr_en_i & ready & (active == SideRight);
    assign snooper_done_left_o     = snooper_done_i & ready & (active == SideLeft);
    assign snooper_done_right_o    = snooper_done_i & ready & (active == SideRight);

    always_comb begin
        pkt_d  = pkt_q;
        drop_d = drop_q;
        if (snooper_done_i && ready && pkt_q != {CNT_WIDTH{1'b1}}) begin
            pkt_d = pkt_q + CNT_WIDTH'(1);
        end
        // One drop per stalled cycle, whether it carried a write, a done or both.
        if ((snooper_wr_en_i || snooper_done_i) && !ready && drop_q != {CNT_WIDTH{1'b1}}) begin
            drop_d = drop_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
        end
    end

    assign pkt_count_o  = pkt_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_inorder_split.sv
// Directed bench for inorder_split: strict, first-ready and 4-bit-counter builds
// share one stimulus and are checked against a packet-level model every cycle.
module tb_inorder_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  addr = '0;
    logic [63:0] data = '0;
    logic        we = 1'b0, dn = 1'b0, rl = 1'b1, rr = 1'b1;

    logic        ro [3], wl [3], wr [3], dl [3], dr [3];
    logic [8:0]  al [3], ar [3];
    logic [63:0] tl [3], tr [3];
    logic [31:0] pc [3], dc [3];
    logic [3:0]  pc_c, dc_c;

    int n_chk = 0, n_fail = 0;
    bit primed = 1'b0;

    // Model: packet-level view per build.
    bit             strict [3] = '{1'b1, 1'b0, 1'b1};
    longint         cmax   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    bit             in_pkt [3], pside [3], nxt [3];
    longint         m_pkt  [3], m_drop [3];

    always #5 clk = ~clk;

    inorder_split #(.STRICT_ORDER(1'b1), .CNT_WIDTH(32)) u_s (
        .clk_i(clk), .rst_i(rst), .snooper_wr_addr_i(addr), .snooper_wr_data_i(data),
        .snooper_wr_en_i(we), .snooper_done_i(dn), .ready_for_snooper_o(ro[0]),
        .snooper_wr_addr_left_o(al[0]), .snooper_wr_addr_right_o(ar[0]),
        .snooper_wr_data_left_o(tl[0]), .snooper_wr_data_right_o(tr[0]),
        .snooper_wr_en_left_o(wl[0]), .snooper_wr_en_right_o(wr[0]),
        .snooper_done_left_o(dl[0]), .snooper_done_right_o(dr[0]),
        .ready_for_snooper_left_i(rl), .ready_for_snooper_right_i(rr),
        .pkt_count_o(pc[0]), .drop_count_o(dc[0])
    );

    inorder_split #(.STRICT_ORDER(1'b0), .CNT_WIDTH(32)) u_f (
        .clk_i(clk), .rst_i(rst), .snooper_wr_addr_i(addr), .snooper_wr_data_i(data),
        .snooper_wr_en_i(we), .snooper_done_i(dn), .ready_for_snooper_o(ro[1]),
        .snooper_wr_addr_left_o(al[1]), .snooper_wr_addr_right_o(ar[1]),
        .snooper_wr_data_left_o(tl[1]), .snooper_wr_data_right_o(tr[1]),
        .snooper_wr_en_left_o(wl[1]), .snooper_wr_en_right_o(wr[1]),
        .snooper_done_left_o(dl[1]), .snooper_done_right_o(dr[1]),
        .ready_for_snooper_left_i(rl), .ready_for_snooper_right_i(rr),
        .pkt_count_o(pc[1]), .drop_count_o(dc[1])
    );

    inorder_split #(.STRICT_ORDER(1'b1), .CNT_WIDTH(4)) u_c (
        .clk_i(clk), .rst_i(rst), .snooper_wr_addr_i(addr), .snooper_wr_data_i(data),
        .snooper_wr_en_i(we), .snooper_done_i(dn), .ready_for_snooper_o(ro[2]),
        .snooper_wr_addr_left_o(al[2]), .snooper_wr_addr_right_o(ar[2]),
        .snooper_wr_data_left_o(tl[2]), .snooper_wr_data_right_o(tr[2]),
        .snooper_wr_en_left_o(wl[2]), .snooper_wr_en_right_o(wr[2]),
        .snooper_done_left_o(dl[2]), .snooper_done_right_o(dr[2]),
        .ready_for_snooper_left_i(rl), .ready_for_snooper_right_i(rr),
        .pkt_count_o(pc_c), .drop_count_o(dc_c)
    );

    assign pc[2] = {28'd0, pc_c};
    assign dc[2] = {28'd0, dc_c};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Side owning the current packet, or the side the next packet would go to.
    function automatic bit m_side(int i);
        if (in_pkt[i]) return pside[i];
        if (strict[i]) return nxt[i];
        return rl ? 1'b0 : 1'b1;
    endfunction

    function automatic bit m_rdy(int i);
        if (rst) return 1'b0;
        return m_side(i) ? rr : rl;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                in_pkt[i] = 1'b0; pside[i] = 1'b0; nxt[i] = 1'b0;
                m_pkt[i] = 0; m_drop[i] = 0;
            end else if (m_rdy(i)) begin
                if (dn) begin
                    if (m_pkt[i] < cmax[i]) m_pkt[i]++;
                    if (strict[i]) nxt[i] = ~m_side(i);
                    in_pkt[i] = 1'b0;
                end else if (we) begin
                    pside[i] = m_side(i);
                    in_pkt[i] = 1'b1;
                end
            end else if (we || dn) begin
                if (m_drop[i] < cmax[i]) m_drop[i]++;
            end
        end
        primed = 1'b1;
    end

    always @(negedge clk) begin
        if (primed) begin
            for (int i = 0; i < 3; i++) begin
                bit s, r;
                s = m_side(i);
                r = m_rdy(i);
                chk($sformatf("ready[%0d]", i), 64'(ro[i]), 64'(r));
                chk($sformatf("wr_en_left[%0d]", i), 64'(wl[i]), 64'(we & r & ~s));
                chk($sformatf("wr_en_right[%0d]", i), 64'(wr[i]), 64'(we & r & s));
                chk($sformatf("done_left[%0d]", i), 64'(dl[i]), 64'(dn & r & ~s));
                chk($sformatf("done_right[%0d]", i), 64'(dr[i]), 64'(dn & r & s));
                chk($sformatf("addr_fanout[%0d]", i), {al[i], ar[i]}, {addr, addr});
                chk($sformatf("data_left[%0d]", i), tl[i], data);
                chk($sformatf("data_right[%0d]", i), tr[i], data);
                chk($sformatf("pkt_count[%0d]", i), 64'(pc[i]), 64'(m_pkt[i]));
                chk($sformatf("drop_count[%0d]", i), 64'(dc[i]), 64'(m_drop[i]));
            end
        end
    end

    task automatic drv(input bit w, input bit d, input int a, input bit l, input bit r);
        @(posedge clk);
        #1;
        we = w; dn = d; addr = 9'(a); rl = l; rr = r;
        data = {$urandom, $urandom};
    endtask

    task automatic pkt4(input bit l, input bit r);
        for (int a = 0; a < 4; a++) drv(1'b1, 1'b0, a, l, r);
        drv(1'b0, 1'b1, 0, l, r);
    endtask

    initial begin
        repeat (2) drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ready held low in reset", 64'(ro[0]), 64'd0);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("reset pkt_count", 64'(pc[0]), 64'd0);
        chk("reset ready follows left", 64'(ro[0]), 64'd1);

        // Three packets alternate left, right, left.
        pkt4(1'b1, 1'b1);
        drv(1'b1, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("pkt2 word0 right", 64'(wr[0]), 64'd1);
        chk("pkt2 word0 not left", 64'(wl[0]), 64'd0);
        for (int a = 1; a < 4; a++) drv(1'b1, 1'b0, a, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 0, 1'b1, 1'b1);
        pkt4(1'b1, 1'b1);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("three packets pkt_count", 64'(pc[0]), 64'd3);
        chk("three packets drop_count", 64'(dc[0]), 64'd0);
        chk("4-bit build pkt_count", 64'(pc[2]), 64'd3);

        // Turn is right but right not ready: strict stalls and drops.
        drv(1'b1, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("strict stall ready", 64'(ro[0]), 64'd0);
        chk("strict stall no left write", 64'(wl[0]), 64'd0);
        drv(1'b1, 1'b0, 1, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("strict stall drop_count", 64'(dc[0]), 64'd2);
        drv(1'b1, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("after stall goes right", 64'(wr[0]), 64'd1);
        for (int a = 1; a < 4; a++) drv(1'b1, 1'b0, a, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 0, 1'b1, 1'b1);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("after stall pkt_count", 64'(pc[0]), 64'd4);

        // First-ready: left down so packet goes right and stays there.
        drv(1'b1, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("first-ready picks right", 64'(wr[1]), 64'd1);
        drv(1'b1, 1'b0, 1, 1'b0, 1'b1);
        drv(1'b1, 1'b0, 2, 1'b1, 1'b1);
        @(negedge clk);
        chk("first-ready locked right", 64'(wr[1]), 64'd1);
        chk("first-ready no left mid-pkt", 64'(wl[1]), 64'd0);
        drv(1'b1, 1'b0, 3, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("first-ready done right", 64'(dr[1]), 64'd1);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("first-ready next goes left", 64'(wl[1]), 64'd1);
        for (int a = 1; a < 4; a++) drv(1'b1, 1'b0, a, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 0, 1'b1, 1'b1);

        // Zero-length packet, then write+done in one cycle.
        drv(1'b0, 1'b1, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("zero-length done left", 64'(dl[0]), 64'd1);
        chk("zero-length no done right", 64'(dr[0]), 64'd0);
        drv(1'b1, 1'b1, 5, 1'b1, 1'b1);
        @(negedge clk);
        chk("one-word write right", 64'(wr[0]), 64'd1);
        chk("one-word done right", 64'(dr[0]), 64'd1);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("short packets pkt_count", 64'(pc[0]), 64'd8);
        chk("short packets drop_count", 64'(dc[0]), 64'd4);

        // Reset in the middle of a left packet.
        drv(1'b1, 1'b0, 0, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1; we = 1'b0; dn = 1'b1;
        @(negedge clk);
        chk("no done_left under reset", 64'(dl[0]), 64'd0);
        chk("no ready under reset", 64'(ro[0]), 64'd0);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset pkt_count", 64'(pc[0]), 64'd0);
        chk("post-reset drop_count", 64'(dc[0]), 64'd0);
        chk("post-reset ready left", 64'(ro[0]), 64'd1);
        drv(1'b0, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post-reset turn is left", 64'(ro[0]), 64'd0);

        // Saturation of the 4-bit drop counter.
        for (int k = 0; k < 20; k++) drv(1'b1, 1'b0, k, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("drop_count 32-bit", 64'(dc[0]), 64'd20);
        chk("drop_count saturates", 64'(dc[2]), 64'd15);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
